// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and helpers shared by the instruction-fetch front end.
// Provides the instruction word size, PC alignment mask and counter-width helper.
package fetch_pkg;

    localparam int WORD_BYTES = 4;
    localparam int INSTR_W    = 32;
    localparam int ALIGN_MASK = WORD_BYTES - 1;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO holding {pc, instr} entries for the IF/ID boundary.
// Ports: clk, rst (sync, active-low), flush, push/push_data, pop, head (0 when empty), count.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head,
    output logic [cnt_w(DEPTH)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Flush voids any push or pop in the same cycle.
    assign do_push = push && !flush;
    assign do_pop  = pop && (count != '0) && !flush;

    // Head reads as zero when empty so the outputs are clean after reset.
    assign head = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case (1'b1)
                (do_push && !do_pop): count <= count + CW'(1);
                (do_pop && !do_push): count <= count - CW'(1);
                default:              count <= count;
            endcase
        end
    end

    // The issue credit keeps a push from ever landing on a full queue.
    always_ff @(posedge clk) begin
        if (rst && do_push && !do_pop) begin
            assert (count != CW'(DEPTH));
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: pipelined instruction fetch with prefetch queue and redirect flush.
// Ports: clk, rst (sync, active-low); imem_req_* / imem_rsp_* memory side;
// redirect_valid/redirect_pc from ID; out_valid/out_ready/out_pc/out_instr to IF/ID; occupancy.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_W-1:0]     imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INSTR_W-1:0]    imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_W-1:0]     redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_W-1:0]     out_pc,
    output logic [INSTR_W-1:0]    out_instr,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int OW = cnt_w(MAX_OUT);
    localparam int QW = cnt_w(DEPTH);
    localparam int SW = ((OW > QW) ? OW : QW) + 1;
    localparam int EW = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [ADDR_W-1:0] target;
    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     outstanding_next;
    logic [OW-1:0]     drop;
    logic [SW-1:0]     credit_used;
    logic              req_fire;
    logic              push;
    logic              pop;
    logic [EW-1:0]     head;

    assign target = redirect_pc & ~ADDR_W'(ALIGN_MASK);

    // Slots already promised: queued entries plus live (non-dropped) requests.
    assign credit_used = SW'(occupancy) + SW'(outstanding) - SW'(drop);

    // Held low while reset is asserted so nothing is offered to the memory.
    assign imem_req_valid = rst && !redirect_valid
                          && (credit_used < SW'(DEPTH))
                          && (outstanding < OW'(MAX_OUT));
    assign imem_req_addr  = fetch_pc;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign push     = imem_rsp_valid && (drop == '0) && !redirect_valid;
    assign pop      = out_valid && out_ready && !redirect_valid;

    assign outstanding_next = outstanding + OW'(req_fire) - OW'(imem_rsp_valid);

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                fetch_pc <= target;
                rsp_pc   <= target;
                // Every request still in flight after this cycle is wrong-path.
                drop     <= outstanding_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + ADDR_W'(WORD_BYTES);
                end
                if (push) begin
                    rsp_pc <= rsp_pc + ADDR_W'(WORD_BYTES);
                end
                if (imem_rsp_valid && (drop != '0)) begin
                    drop <= drop - OW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (imem_rsp_valid) begin
                assert (outstanding != '0);
            end
            assert (drop <= outstanding);
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({rsp_pc, imem_rsp_data}),
        .pop       (pop),
        .head      (head),
        .count     (occupancy)
    );

    assign out_valid = (occupancy != '0);
    assign out_pc    = head[EW-1:INSTR_W];
    assign out_instr = head[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a latency-programmable memory.
// Expected stream: after reset/redirect to T, instructions at T, T+4, ... with data mem(pc).
module tb_fetch_unit;

    localparam int          ADDR_W   = 32;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  occupancy;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .MAX_OUT  (MAX_OUT),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .occupancy      (occupancy)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    pend_t       pend[$];
    exp_t        sb[$];
    logic [31:0] pop_log[$];
    logic [31:0] model_pc = RESET_PC;

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int last_due   = 0;
    int out_tb     = 0;
    int lat        = 1;
    int total_pops = 0;
    bit rnd_mode   = 0;
    bit want_ready = 1;
    bit want_req   = 1;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk_eq(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_le(input string name, input int a, input int b);
        checks++;
        if (!(a <= b)) begin
            failures++;
            $display("FAIL %s: got %0d want <= %0d", name, a, b);
        end
    endtask

    // Drive phase: one tick after the rising edge.
    task automatic tick_start();
        @(posedge clk);
        #1;
        cyc++;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : want_req;
        out_ready      = rnd_mode ? ($urandom_range(0, 3) != 0) : want_ready;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(pend[0].addr);
            pend.delete(0);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    // Observe phase: falling edge, all inputs and outputs settled.
    task automatic tick_end();
        int l;
        int due;
        @(negedge clk);
        if (!rst) begin
            pend.delete();
            sb.delete();
            out_tb   = 0;
            model_pc = RESET_PC;
            return;
        end
        if (imem_rsp_valid) out_tb--;
        if (imem_req_valid && imem_req_ready) begin
            l = rnd_mode ? int'($urandom_range(1, 4)) : lat;
            chk_eq("req_addr", imem_req_addr, model_pc);
            due = cyc + l;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{imem_req_addr, due});
            sb.push_back('{model_pc, memf(model_pc)});
            model_pc += 32'd4;
            out_tb++;
        end
        if (redirect_valid) begin
            chk_eq("redirect_no_req", imem_req_valid, 1'b0);
            sb.delete();
            model_pc = redirect_pc & ~32'h3;
        end
        chk_le("outstanding", out_tb, MAX_OUT);
        chk_eq("valid_vs_occ", out_valid, occupancy != 0);
        chk_le("occ_max", occupancy, DEPTH);
    endtask

    task automatic cycle();
        tick_start();
        tick_end();
    endtask

    task automatic wait_pops(input int n, input int bound, input string name);
        int i;
        i = 0;
        while (pop_log.size() < n && i < bound) begin
            cycle();
            i++;
        end
        chk_le(name, n, pop_log.size());
    endtask

    // Monitor: every accepted head must match the scoreboard front.
    always @(negedge clk) begin
        if (rst && !redirect_valid && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_unexpected: got pc %h want none", out_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk_eq("out_pc", out_pc, e.pc);
                chk_eq("out_instr", out_instr, e.instr);
                pop_log.push_back(out_pc);
                total_pops++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;

        // Reset values while reset is held.
        repeat (3) begin
            tick_start();
            rst = 1'b0;
            tick_end();
        end
        chk_eq("rst_req_valid", imem_req_valid, 1'b0);
        chk_eq("rst_out_valid", out_valid, 1'b0);
        chk_eq("rst_occ", occupancy, 3'd0);
        chk_eq("rst_out_pc", out_pc, 32'h0);
        chk_eq("rst_out_instr", out_instr, 32'h0);

        // Streaming: 1-cycle memory, first output two cycles after release.
        lat = 1;
        want_ready = 1;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (i < 2) chk_eq("stream_early", out_valid, 1'b0);
            else       chk_eq("stream_gap", out_valid, 1'b1);
            if (i == 2) chk_eq("stream_first_pc", out_pc, RESET_PC);
        end

        // Backpressure: queue saturates, then resumes in order.
        want_ready = 0;
        repeat (10) cycle();
        chk_eq("bp_occ", occupancy, 3'd4);
        chk_eq("bp_req_off", imem_req_valid, 1'b0);
        want_ready = 1;
        pop_log.delete();
        repeat (12) cycle();
        chk_le("bp_resume", 8, pop_log.size());

        // Redirect with two requests in flight on a 3-cycle memory.
        lat = 3;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick_start();
            if (out_tb == 2) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h100;
                pop_log.delete();
                found = 1;
            end
            tick_end();
        end
        chk_eq("rd_found", found, 1'b1);
        wait_pops(1, 40, "rd_timeout");
        if (pop_log.size() >= 1) chk_eq("rd_first_pc", pop_log[0], 32'h100);

        // Redirect in the same cycle as a response and a pop.
        lat = 2;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick_start();
            if (imem_rsp_valid && out_valid && out_ready) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h200;
                pop_log.delete();
                found = 1;
            end
            tick_end();
        end
        chk_eq("co_found", found, 1'b1);
        cycle();
        chk_eq("co_occ", occupancy, 3'd0);
        chk_eq("co_valid", out_valid, 1'b0);
        wait_pops(1, 40, "co_timeout");
        if (pop_log.size() >= 1) chk_eq("co_first_pc", pop_log[0], 32'h200);

        // Misaligned target near the top of the address space.
        lat = 1;
        tick_start();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        pop_log.delete();
        tick_end();
        wait_pops(2, 40, "wrap_timeout");
        if (pop_log.size() >= 2) begin
            chk_eq("wrap_pc0", pop_log[0], 32'hFFFF_FFFC);
            chk_eq("wrap_pc1", pop_log[1], 32'h0000_0000);
        end

        // Mid-stream reset with a full queue.
        want_ready = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (occupancy == 3'd4) found = 1;
        end
        chk_eq("mr_full", found, 1'b1);
        tick_start();
        rst = 1'b0;
        tick_end();
        tick_start();
        chk_eq("mr_req_addr", imem_req_addr, RESET_PC);
        tick_end();
        chk_eq("mr_valid", out_valid, 1'b0);
        chk_eq("mr_occ", occupancy, 3'd0);
        want_ready = 1;
        pop_log.delete();
        wait_pops(1, 20, "mr_timeout");
        if (pop_log.size() >= 1) chk_eq("mr_first_pc", pop_log[0], RESET_PC);

        // Random traffic: variable latency, stalls, redirects.
        rnd_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            tick_start();
            if ($urandom_range(0, 39) == 0) begin
                redirect_valid = 1'b1;
                case ($urandom_range(0, 2))
                    0:       redirect_pc = $urandom;
                    1:       redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                    default: redirect_pc = $urandom & 32'h0000_0FFF;
                endcase
            end
            tick_end();
        end
        rnd_mode = 0;

        // Drain: stop issuing and empty everything.
        want_req   = 0;
        want_ready = 1;
        repeat (30) cycle();
        chk_eq("drain_sb", sb.size(), 0);
        chk_eq("drain_occ", occupancy, 3'd0);
        chk_eq("drain_pend", pend.size(), 0);
        chk_le("rand_progress", 200, total_pops);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end replacing the single-PC, zero-latency fetch of the current core. Issues sequential requests to an instruction memory over a valid/ready interface and tolerates multi-cycle, in-order responses. Buffers returned instructions in a prefetch queue that feeds the IF/ID boundary. Handles branch redirects by flushing the queue and discarding in-flight wrong-path responses.

Parameters:
ADDR_W, 32, width of PC and memory address
DEPTH, 4, prefetch queue entries; power of 2, minimum 2
MAX_OUT, 2, maximum outstanding memory requests, 1..DEPTH
RESET_PC, 0, PC fetched first after reset; must be word aligned

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-low
imem_req_valid  output  1  request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  ADDR_W  word-aligned fetch address
imem_rsp_valid  input  1  response data valid; responses return in request order, with no backpressure
imem_rsp_data  input  32  instruction word
redirect_valid  input  1  branch taken / flush request from ID
redirect_pc  input  ADDR_W  new fetch PC; bits [1:0] ignored and treated as 0
out_valid  output  1  queue head valid
out_ready  input  1  consumer accepts head (IF/ID write enable)
out_pc  output  ADDR_W  PC of head instruction
out_instr  output  32  head instruction
occupancy  output  $clog2(DEPTH)+1  number of queue entries (debug)

Behaviour:
- Reset (rst==0 at a clock edge):
  - fetch_pc=RESET_PC, rsp_pc=RESET_PC.
  - Queue empty; outstanding=0, drop=0.
  - Outputs: out_valid=0, imem_req_valid=0, occupancy=0, out_pc=0, out_instr=0.
  - The memory shares this reset, so no response arrives for a pre-reset request.
- Request issue:
  - imem_req_valid=1 when (occupancy + outstanding - drop) < DEPTH, outstanding < MAX_OUT, and redirect_valid==0.
  - imem_req_valid is combinational from registered state and redirect_valid.
  - imem_req_addr=fetch_pc.
  - On handshake: fetch_pc += 4, wrapping modulo 2^ADDR_W; outstanding += 1.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - If drop>0: data discarded, drop -= 1.
  - Else: {rsp_pc, imem_rsp_data} pushed to queue, rsp_pc += 4.
  - The credit rule guarantees a push never overflows the queue. An overflow is an assertion failure.
- Output:
  - First-word-fall-through: out_valid = occupancy != 0; out_pc/out_instr = head.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Minimum latency: request accepted at cycle N with 1-cycle memory -> response at N+1 -> out_valid at N+2.
- Redirect (redirect_valid==1), priority over every other event that cycle:
  - Queue flushed; any concurrent pop is void.
  - fetch_pc = redirect_pc & ~3; rsp_pc = same.
  - No request issued that cycle.
  - drop_next = outstanding_next, where outstanding_next already accounts for a response arriving that cycle. A response in the redirect cycle is always discarded.
  - Back-to-back redirects: the last one wins; drop tracks all in-flight requests.
  - Fetch resumes the cycle after the redirect.
- Counters are $clog2(MAX_OUT)+1 bits and never underflow. drop <= outstanding at all times.
- Reset mid-operation abandons all state with no drain.

Decomposition:
- Package fetch_pkg: word-size constant (4), PC alignment mask, and a helper function for counter widths ($clog2-based).
- One sub-module, fetch_queue:
  - Parametrised synchronous FIFO, DEPTH entries, each ADDR_W+32 bits.
  - Ports: push, pop, flush, data in, head out, count out.
  - Flush has priority over push and pop.
  - Wrap-around read/write pointers plus a count register.
- The fetch_unit top holds fetch_pc, rsp_pc, the outstanding and drop counters, and the credit/issue logic.

Test Plan:
- Streaming: reset release, ready=1, 1-cycle memory, out_ready=1 -> out_pc sequence 0x0,0x4,0x8,... one per cycle from cycle 2 onward; outstanding never exceeds 2.
- Backpressure: out_ready=0 for 10 cycles -> occupancy saturates at 4, imem_req_valid=0, no overflow. Then out_ready=1 -> PCs continue in order with no gap or duplicate.
- Redirect with in-flight requests: 3-cycle memory, 2 outstanding, redirect_pc=0x100 -> both stale responses dropped; next out_pc=0x100, out_instr=mem[0x100].
- Redirect coinciding with a response and a pop: queue flushed, that response dropped, drop=1. The first delivered instruction has out_pc=redirect target.
- Misaligned/wrap: redirect_pc=0xFFFFFFFE -> fetch at 0xFFFFFFFC, then 0x0 after wrap.
- Mid-stream reset: assert rst=0 for 1 cycle while queue is full -> next cycle out_valid=0, occupancy=0, and first request addr=RESET_PC.
